// File: rtl/cc_speed_scheduler_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cc_speed_scheduler_pkg : shared game constants, scheduler state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
package cc_speed_scheduler_pkg;

  localparam int c_level_w         = 3;
  localparam logic [c_level_w-1:0] c_level_max = 3'd7;
  localparam int c_lane_cnt_w      = 3;
  localparam int c_base_tc_default = 4000000;
  localparam int c_step_tc_default = 400000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_LVLCHG = 2'd3
  } sched_state_t;

  function automatic logic [c_level_w-1:0] level_inc(input logic [c_level_w-1:0] lvl);
    return (lvl == c_level_max) ? lvl : lvl + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cc_lane_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cc_lane_divider : divides the movement tick by LANE_IDX+1, registered strobe
// Rev 1.0
// ----------------------------------------------------------------------------
module cc_lane_divider
  import cc_speed_scheduler_pkg::*;
#(
  parameter int LANE_IDX = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_shift
);

  localparam logic [c_lane_cnt_w-1:0] c_last = c_lane_cnt_w'(LANE_IDX);

  logic [c_lane_cnt_w-1:0] r_cnt;
  logic                    r_shift;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_shift <= 1'b0;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_shift <= 1'b0;
    end else if (i_tick) begin
      r_shift <= (r_cnt == c_last);
      r_cnt   <= (r_cnt == c_last) ? '0 : r_cnt + 3'd1;
    end else begin
      r_shift <= 1'b0;
    end
  end

  assign o_shift = r_shift;

endmodule
`default_nettype wire

// File: rtl/cc_speed_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cc_speed_scheduler : level FSM, level-dependent prescaler tick, lane strobes
// Rev 1.0
// ----------------------------------------------------------------------------
module cc_speed_scheduler
  import cc_speed_scheduler_pkg::*;
#(
  parameter int SCHED_DATAWIDTH = 23,
  parameter int SCHED_BASE_TC   = c_base_tc_default,
  parameter int SCHED_STEP_TC   = c_step_tc_default,
  parameter int SCHED_LANES     = 4
) (
  input  logic                   CC_SPEED_SCHEDULER_CLOCK_50,
  input  logic                   CC_SPEED_SCHEDULER_RESET_InLow,
  input  logic                   CC_SPEED_SCHEDULER_start_InLow,
  input  logic                   CC_SPEED_SCHEDULER_pause_InLow,
  input  logic                   CC_SPEED_SCHEDULER_levelUp_InHigh,
  input  logic                   CC_SPEED_SCHEDULER_gameOver_InHigh,
  output logic                   CC_SPEED_SCHEDULER_tick_OutHigh,
  output logic [SCHED_LANES-1:0] CC_SPEED_SCHEDULER_laneShift_OutBUS,
  output logic [c_level_w-1:0]   CC_SPEED_SCHEDULER_CurrentLevel_OutBUS,
  output logic                   CC_SPEED_SCHEDULER_levelMax_OutHigh,
  output logic                   CC_SPEED_SCHEDULER_running_OutHigh
);

  // Highest level must still leave a non-negative terminal count that fits.
  if ((SCHED_STEP_TC < 0) ||
      (SCHED_BASE_TC < int'(c_level_max) * SCHED_STEP_TC) ||
      (64'(SCHED_BASE_TC) >= (64'd1 << SCHED_DATAWIDTH)) ||
      (SCHED_LANES < 1) || (SCHED_LANES > 8)) begin : g_param_check
    $error("cc_speed_scheduler: illegal terminal-count or lane parameters");
  end

  sched_state_t                r_state;
  sched_state_t                w_state_next;
  logic [SCHED_DATAWIDTH-1:0]  r_presc;
  logic [SCHED_DATAWIDTH-1:0]  w_tc;
  logic [c_level_w-1:0]        r_level;
  logic [c_level_w-1:0]        w_level_next;
  logic                        r_tick;
  logic                        r_running;
  logic                        r_level_max;
  logic                        w_in_run;
  logic                        w_match;
  logic                        w_fire;
  logic                        w_clear;
  logic [SCHED_LANES-1:0]      w_lane_shift;

  wire w_clk       = CC_SPEED_SCHEDULER_CLOCK_50;
  wire w_rst_n     = CC_SPEED_SCHEDULER_RESET_InLow;
  wire w_start     = ~CC_SPEED_SCHEDULER_start_InLow;
  wire w_pause     = ~CC_SPEED_SCHEDULER_pause_InLow;
  wire w_lvl_up    = CC_SPEED_SCHEDULER_levelUp_InHigh;
  wire w_game_over = CC_SPEED_SCHEDULER_gameOver_InHigh;

  assign w_tc     = SCHED_DATAWIDTH'(SCHED_BASE_TC - SCHED_STEP_TC * int'(r_level));
  assign w_in_run = (r_state == ST_RUN);
  assign w_match  = (r_presc == w_tc);
  // Level change and game over both outrank a coincident terminal count.
  assign w_fire   = w_in_run && w_match && !w_lvl_up && !w_game_over;
  assign w_clear  = w_game_over || (r_state == ST_LVLCHG);

  always_comb begin
    w_state_next = r_state;
    if (w_game_over) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_start) w_state_next = ST_RUN;
        ST_RUN: begin
          if (w_lvl_up)     w_state_next = ST_LVLCHG;
          else if (w_pause) w_state_next = ST_PAUSE;
        end
        ST_PAUSE:  if (w_start && !w_pause) w_state_next = ST_RUN;
        ST_LVLCHG: w_state_next = ST_RUN;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_level_next = r_level;
    if (w_game_over)                w_level_next = '0;
    else if (r_state == ST_LVLCHG)  w_level_next = level_inc(r_level);
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_IDLE;
      r_presc     <= '0;
      r_level     <= '0;
      r_tick      <= 1'b0;
      r_running   <= 1'b0;
      r_level_max <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_level     <= w_level_next;
      r_tick      <= w_fire;
      r_running   <= (w_state_next == ST_RUN);
      r_level_max <= (w_level_next == c_level_max);
      if (w_clear) begin
        r_presc <= '0;
      end else if (w_in_run && !w_lvl_up) begin
        r_presc <= w_match ? '0 : r_presc + SCHED_DATAWIDTH'(1);
      end
    end
  end

  for (genvar g = 0; g < SCHED_LANES; g++) begin : g_lane
    cc_lane_divider #(
      .LANE_IDX (g)
    ) u_lane_divider (
      .i_clk   (w_clk),
      .i_rst_n (w_rst_n),
      .i_clear (w_clear),
      .i_tick  (w_fire),
      .o_shift (w_lane_shift[g])
    );
  end

  assign CC_SPEED_SCHEDULER_tick_OutHigh        = r_tick;
  assign CC_SPEED_SCHEDULER_laneShift_OutBUS    = w_lane_shift;
  assign CC_SPEED_SCHEDULER_CurrentLevel_OutBUS = r_level;
  assign CC_SPEED_SCHEDULER_levelMax_OutHigh    = r_level_max;
  assign CC_SPEED_SCHEDULER_running_OutHigh     = r_running;

endmodule
`default_nettype wire

// File: doc/cc_speed_scheduler.md
CC_SPEED_SCHEDULER -- requirements
Module: cc_speed_scheduler

Interface
REQ-001 SHALL have parameter SCHED_DATAWIDTH, default 23: width of the prescaler counter.
REQ-002 SHALL have parameter SCHED_BASE_TC, default 4000000: level-0 terminal count.
REQ-003 SHALL have parameter SCHED_STEP_TC, default 400000: terminal-count decrement per level.
REQ-004 SHALL have parameter SCHED_LANES, default 4: number of obstacle lanes.
REQ-005 SHALL have port CC_SPEED_SCHEDULER_CLOCK_50, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 SHALL have port CC_SPEED_SCHEDULER_RESET_InLow, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port CC_SPEED_SCHEDULER_start_InLow, input, 1 bit: start or resume request, active low, level-sampled.
REQ-008 SHALL have port CC_SPEED_SCHEDULER_pause_InLow, input, 1 bit: pause request, active low.
REQ-009 SHALL have port CC_SPEED_SCHEDULER_levelUp_InHigh, input, 1 bit: one-cycle pulse when the frog completes a level.
REQ-010 SHALL have port CC_SPEED_SCHEDULER_gameOver_InHigh, input, 1 bit: one-cycle pulse when the game is lost.
REQ-011 SHALL have port CC_SPEED_SCHEDULER_tick_OutHigh, output, 1 bit: one-cycle movement tick.
REQ-012 SHALL have port CC_SPEED_SCHEDULER_laneShift_OutBUS, output, SCHED_LANES bits: one-cycle per-lane shift strobes.
REQ-013 SHALL have port CC_SPEED_SCHEDULER_CurrentLevel_OutBUS, output, 3 bits: current level, 0..7.
REQ-014 SHALL have port CC_SPEED_SCHEDULER_levelMax_OutHigh, output, 1 bit: high when the level equals 7.
REQ-015 SHALL have port CC_SPEED_SCHEDULER_running_OutHigh, output, 1 bit: high when the FSM is in RUN.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, PAUSE and LVLCHG.
- IDLE -> RUN on start low.
- RUN -> PAUSE on pause low.
- PAUSE -> RUN on start low while pause is high.
- RUN -> LVLCHG on levelUp.
- LVLCHG -> RUN unconditionally after 1 cycle.
- Any state -> IDLE on gameOver.
REQ-017 SHALL compute terminal count TC(L) = SCHED_BASE_TC - L*SCHED_STEP_TC in SCHED_DATAWIDTH bits; this product SHALL never underflow, checked by an elaboration-time assertion.
REQ-018 In RUN, the prescaler SHALL increment every cycle.
- When prescaler == TC(level): assert tick for exactly 1 cycle and set prescaler to 0 on the same edge.
- Tick period SHALL therefore be TC(L)+1 cycles.
REQ-019 Each lane k (0..SCHED_LANES-1) SHALL own a 3-bit tick counter with period k+1 ticks.
- laneShift[k] SHALL pulse in the same cycle as the tick on which lane counter k wraps.
- Lane 0 SHALL therefore pulse on every tick.
REQ-020 In PAUSE and IDLE, the prescaler and lane counters SHALL hold, and tick and laneShift SHALL be 0.
REQ-021 In LVLCHG:
- the level SHALL increment by 1, saturating at 7;
- the prescaler and all lane counters SHALL be cleared;
- no tick SHALL be issued.
REQ-022 If levelUp and the terminal-count condition coincide in RUN, the level change SHALL win and the tick SHALL be suppressed.
REQ-023 If gameOver coincides with any other event, gameOver SHALL win:
- go to IDLE;
- level, prescaler and lane counters cleared;
- no tick issued.
REQ-024 levelUp received at level 7 SHALL still pass through LVLCHG (counters cleared) with the level held at 7.
REQ-025 levelUp received outside RUN SHALL be ignored.
REQ-026 All outputs SHALL be registered, with tick and laneShift valid in the cycle after the prescaler match edge; latency is fixed at 1.
REQ-027 A pause asserted in the same cycle as the terminal count SHALL not suppress that tick; the FSM SHALL enter PAUSE on the next edge.

Reset
REQ-028 On RESET_InLow low, asynchronously:
- state = IDLE;
- prescaler = 0;
- lane counters = 0;
- level = 0;
- tick = 0, laneShift = 0, levelMax = 0, running = 0.
REQ-029 Reset deasserted mid-operation SHALL resume from IDLE; no partial tick SHALL appear on the first post-reset cycle.

Structure
REQ-030 The state encoding, CURRENT_LEVEL width (3) and the default BASE/STEP constants SHALL live in the shared game package.
REQ-031 The per-lane divider SHALL be one sub-module, cc_lane_divider, instantiated SCHED_LANES times by generate.

Verification (bench parameters: BASE_TC=20, STEP_TC=2, LANES=4)
REQ-032 Reset, then start low for 1 cycle -> running=1; first tick 21 cycles later; period 21; level 0.
REQ-033 In RUN at level 0, observe 12 ticks -> the count of laneShift pulses SHALL be:
- 12 on bit 0;
- 6 on bit 1;
- 4 on bit 2;
- 3 on bit 3.
REQ-034 Pulse levelUp on the cycle the prescaler equals 20 -> no tick; level becomes 1; the next tick arrives 19 cycles after LVLCHG exits.
REQ-035 Pulse levelUp 8 times -> level saturates at 7, levelMax=1, tick period 7 cycles.
REQ-036 Pause at prescaler=10, hold 50 cycles, then start -> no tick during pause; the next tick arrives 10 cycles after resume.
REQ-037 gameOver coincident with a tick, then async reset mid-RUN -> IDLE, level=0, all outputs 0 immediately, without waiting for a clock edge.
